// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the simulation run controller.
// Holds the FSM state encoding and the default pass/fail PCs and signature
// register index used by sim_run_controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    StHold    = 3'd0,
    StRun     = 3'd1,
    StPass    = 3'd2,
    StFail    = 3'd3,
    StTimeout = 3'd4
  } run_state_e;

  localparam logic [31:0] DefaultPassPc = 32'h0000_0040;
  localparam logic [31:0] DefaultFailPc = 32'h0000_0044;
  localparam int unsigned DefaultSigReg = 10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset, clears q
//   clr  - synchronous clear (wins over en)
//   en   - increment; holds at all-ones once reached
//   q    - count value
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sim_run_controller.sv
// Simulation run controller: holds the core in reset for RST_CYCLES, then
// watches retired instructions and write-backs to decide pass, fail or timeout.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   core_rst                 - reset to the core pipeline (high in HOLD)
//   retire_valid, retire_pc  - retirement stream from the core
//   wb_en, wb_rd, wb_data    - register write-back stream
//   state                    - current FSM state encoding
//   cycle_count, instr_count - RUN cycles and RUN retires (saturating)
//   signature                - last value written to SIG_REG
//   done, pass, fail, timeout- registered sticky verdicts
module sim_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      CNT_W       = 32,
  parameter int unsigned      RST_CYCLES  = 2,
  parameter int unsigned      MAX_CYCLES  = 20,
  parameter logic [XLEN-1:0]  PASS_PC     = DefaultPassPc,
  parameter logic [XLEN-1:0]  FAIL_PC     = DefaultFailPc,
  parameter int unsigned      HALT_REPEAT = 3,
  parameter int unsigned      SIG_REG     = DefaultSigReg
) (
  input  logic             clk,
  input  logic             rst,
  output logic             core_rst,
  input  logic             retire_valid,
  input  logic [XLEN-1:0]  retire_pc,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [XLEN-1:0]  signature,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout
);

  run_state_e      state_q, state_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic [3:0]      rep_cnt_q, rep_cnt_d;
  logic [XLEN-1:0] last_pc_q, last_pc_d;
  logic [XLEN-1:0] signature_q, signature_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic            timeout_q, timeout_d;

  logic in_run, sig_wr, fail_hit, pass_hit, halt_hit, timeout_hit;

  assign in_run      = (state_q == StRun);
  assign sig_wr      = in_run && wb_en && (wb_rd == 5'(SIG_REG)) && (wb_rd != 5'd0);
  assign fail_hit    = retire_valid && (retire_pc == FAIL_PC);
  assign pass_hit    = retire_valid && (retire_pc == PASS_PC);
  assign timeout_hit = (cycle_count == CNT_W'(MAX_CYCLES - 1));

  // Cycle counter stops at MAX_CYCLES-1 so it reads the value that triggered the timeout.
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == StHold),
    .en  (in_run && !timeout_hit),
    .q   (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == StHold),
    .en  (in_run && retire_valid),
    .q   (instr_count)
  );

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    last_pc_d   = last_pc_q;
    signature_d = signature_q;
    halt_hit    = 1'b0;

    unique case (state_q)
      StHold: begin
        if (hold_cnt_q == 8'(RST_CYCLES - 1)) begin
          state_d    = StRun;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      StRun: begin
        if (sig_wr) begin
          signature_d = wb_data;
        end
        // Non-retire cycles leave the repeat run untouched.
        if (retire_valid) begin
          last_pc_d = retire_pc;
          rep_cnt_d = ((rep_cnt_q != 4'd0) && (retire_pc == last_pc_q)) ?
                      rep_cnt_q + 4'd1 : 4'd1;
          halt_hit  = (rep_cnt_d == 4'(HALT_REPEAT));
        end
        if (fail_hit) begin
          state_d = StFail;
        end else if (pass_hit) begin
          state_d = StPass;
        end else if (halt_hit) begin
          // Verdict uses the signature including a same-cycle write.
          state_d = (signature_d == '0) ? StPass : StFail;
        end else if (timeout_hit) begin
          state_d = StTimeout;
        end
      end
      default: ;
    endcase

    pass_d    = (state_d == StPass);
    fail_d    = (state_d == StFail);
    timeout_d = (state_d == StTimeout);
    done_d    = pass_d || fail_d || timeout_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      last_pc_q   <= '0;
      signature_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      last_pc_q   <= last_pc_d;
      signature_q <= signature_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
    end
  end

  assign core_rst  = (state_q == StHold);
  assign state     = state_q;
  assign signature = signature_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/sim_run_controller.md
SIM_RUN_CONTROLLER -- requirements
Module: sim_run_controller

Interface
REQ-001 The block SHALL expose the following parameters, one per line: name, default, meaning.
- XLEN, 32: retire PC and write-back data width.
- CNT_W, 32: cycle and instruction counter width.
- RST_CYCLES, 2: cycles core_rst stays high after rst deasserts (legal range 1..255).
- MAX_CYCLES, 20: RUN-cycle budget before timeout (legal range 1..2^CNT_W-1).
- PASS_PC, 32'h0000_0040: retiring this PC ends the run as pass.
- FAIL_PC, 32'h0000_0044: retiring this PC ends the run as fail.
- HALT_REPEAT, 3: consecutive retires of one PC that count as a self-loop halt (legal range 2..15).
- SIG_REG, 10: register index captured as the test signature (a0).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- core_rst  out  1  reset driven to pipeline_top.
- retire_valid  in  1  core retired an instruction this cycle.
- retire_pc  in  XLEN  PC of the retired instruction.
- wb_en  in  1  register write-back strobe.
- wb_rd  in  5  write-back destination register.
- wb_data  in  XLEN  write-back value.
- state  out  3  current FSM state encoding.
- cycle_count  out  CNT_W  cycles spent in RUN.
- instr_count  out  CNT_W  retires counted in RUN.
- signature  out  XLEN  last value written to SIG_REG.
- done, pass, fail, timeout  out  1 each  sticky run verdicts.

Function
REQ-003 The FSM SHALL have the states HOLD, RUN, PASS, FAIL and TIMEOUT, with PASS, FAIL and TIMEOUT terminal until rst.
REQ-004 HOLD SHALL keep core_rst=1 and count RST_CYCLES cycles after rst deasserts, then enter RUN with core_rst=0 on the following edge.
REQ-005 In RUN, cycle_count SHALL increment every cycle, and instr_count SHALL increment on every cycle with retire_valid=1; both counters SHALL saturate at all-ones.
REQ-006 In RUN, when wb_en=1 and wb_rd==SIG_REG, signature SHALL load wb_data on that edge; writes to rd 0 SHALL be ignored even if SIG_REG=0.
REQ-007 A retire with retire_pc==FAIL_PC SHALL move the FSM to FAIL on the next edge.
REQ-008 A retire with retire_pc==PASS_PC SHALL move the FSM to PASS on the next edge.
REQ-009 Self-loop halt: when HALT_REPEAT consecutive retires carry the same PC (non-retire cycles between them do not break the run), the FSM SHALL enter PASS if signature==0, using a value written on the same cycle, and FAIL otherwise.
REQ-010 If none of the above has fired by the time cycle_count reaches MAX_CYCLES-1, the next edge SHALL enter TIMEOUT.
REQ-011 When events coincide on one cycle, priority SHALL be FAIL_PC > PASS_PC > self-loop halt > timeout; if PASS_PC==FAIL_PC, FAIL SHALL win.
REQ-012 done SHALL be 1 in every terminal state; pass, fail and timeout SHALL be one-hot decodes of PASS, FAIL and TIMEOUT.
REQ-013 In terminal states, the counters, signature and core_rst=0 SHALL freeze, and all inputs SHALL be ignored.
REQ-014 Verdict outputs SHALL be registered, with 1-cycle latency from the deciding retire.

Reset
REQ-015 Asserting rst SHALL immediately and asynchronously set the following, at any point including mid-RUN or in a terminal state: state=HOLD, core_rst=1, cycle_count=0, instr_count=0, signature=0, done/pass/fail/timeout=0, hold counter=0, repeat counter=0.
REQ-016 Deasserting rst SHALL restart the HOLD sequence from its first cycle.

Structure
REQ-017 The shared package run_ctrl_pkg SHALL hold the state encodings (HOLD=0, RUN=1, PASS=2, FAIL=3, TIMEOUT=4) and the default PASS_PC, FAIL_PC and SIG_REG constants.
REQ-018 The saturating counter SHALL be one sub-module, sat_counter (parameter W; ports clk, rst, clr, en, q), instantiated twice.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- rst high 3 cycles then low, RST_CYCLES=2 -> core_rst falls exactly 2 edges after rst falls; state=RUN.
- Retires at 0x0,0x4,0x8 then 0x40 -> PASS on the next edge; instr_count=4; pass=1, done=1.
- Write a0=0x5, then 3 retires of 0x20 -> FAIL; signature=0x5.
- No retires, MAX_CYCLES=20 -> TIMEOUT after 20 RUN cycles; cycle_count=19, then frozen.
- Same-cycle retire at 0x44 with the timeout cycle, and PASS_PC=FAIL_PC=0x44 -> fail=1, timeout=0.
- rst pulsed mid-RUN at cycle 7 -> all outputs return to reset values immediately, and HOLD restarts.
